// File: rtl/rf_scoreboard_pkg.sv
// Shared constants, types and helpers for the register file / pending-writer scoreboard.
package rf_scoreboard_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_AW     = 5;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 3;

  typedef logic [ID_WIDTH-1:0]   rob_id_t;
  typedef logic [REG_AW-1:0]     reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [REG_AW:0]       pend_count_t;

  // Number of set bits in the pending vector (wide enough for NUM_REGS).
  function automatic pend_count_t pend_popcount(input logic [NUM_REGS-1:0] vec);
    pend_count_t cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + pend_count_t'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode / commit / read bundle between the pipeline and the register file scoreboard.
interface rf_scoreboard_if;
  import rf_scoreboard_pkg::*;

  // Issue side: decode allocates a destination to an in-flight instruction.
  logic        alloc_valid;
  reg_addr_t   alloc_dest;
  rob_id_t     alloc_instr_id;

  // Commit side from the reorder buffer.
  logic        wb_writeEn;
  reg_data_t   wb_data;
  reg_addr_t   wb_dest;
  rob_id_t     wb_instr_id;

  // Exception flush.
  logic        flush;

  // Operand reads.
  reg_addr_t   rd_src1_addr;
  reg_addr_t   rd_src2_addr;
  reg_data_t   rd_src1_data;
  reg_data_t   rd_src2_data;
  logic        rd_src1_pending;
  logic        rd_src2_pending;
  rob_id_t     rd_src1_tag;
  rob_id_t     rd_src2_tag;

  pend_count_t pending_count;

  // Pipeline side: drives requests, observes results.
  modport master (
    output alloc_valid, alloc_dest, alloc_instr_id,
    output wb_writeEn, wb_data, wb_dest, wb_instr_id,
    output flush,
    output rd_src1_addr, rd_src2_addr,
    input  rd_src1_data, rd_src2_data,
    input  rd_src1_pending, rd_src2_pending,
    input  rd_src1_tag, rd_src2_tag,
    input  pending_count
  );

  // Register file side.
  modport slave (
    input  alloc_valid, alloc_dest, alloc_instr_id,
    input  wb_writeEn, wb_data, wb_dest, wb_instr_id,
    input  flush,
    input  rd_src1_addr, rd_src2_addr,
    output rd_src1_data, rd_src2_data,
    output rd_src1_pending, rd_src2_pending,
    output rd_src1_tag, rd_src2_tag,
    output pending_count
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational operand read port: r0 rule, commit write-through bypass,
// and pending/tag lookup that already accounts for this cycle's matching commit.
module rf_read_port
  import rf_scoreboard_pkg::*;
(
  input  reg_addr_t                  addr,
  input  reg_data_t [NUM_REGS-1:0]   regs,
  input  logic      [NUM_REGS-1:0]   pend,
  input  rob_id_t   [NUM_REGS-1:0]   tags,
  input  logic                       wb_write_en,
  input  reg_addr_t                  wb_dest,
  input  reg_data_t                  wb_data,
  input  rob_id_t                    wb_instr_id,
  output reg_data_t                  data,
  output logic                       pending,
  output rob_id_t                    tag
);

  logic      wb_hit_s;
  reg_data_t data_s;
  logic      pending_s;
  rob_id_t   tag_s;

  assign wb_hit_s = wb_write_en && (wb_dest == addr);

  // Select read data, pending flag and producer tag for the requested register.
  always_comb begin
    data_s    = '0;
    pending_s = 1'b0;
    tag_s     = '0;
    if (addr != '0) begin
      if (wb_hit_s) begin
        data_s = wb_data;
      end else begin
        data_s = regs[addr];
      end
      // A commit from the youngest writer retires the pending state this cycle.
      if (wb_hit_s && (tags[addr] == wb_instr_id)) begin
        pending_s = 1'b0;
      end else begin
        pending_s = pend[addr];
      end
      tag_s = tags[addr];
    end else begin
      data_s    = '0;
      pending_s = 1'b0;
      tag_s     = '0;
    end
  end

  assign data    = data_s;
  assign pending = pending_s;
  assign tag     = tag_s;

endmodule

// File: rtl/rf_scoreboard.sv
// Architectural register file with a per-register pending-writer scoreboard.
// Commits write data and retire the matching writer; allocates mark a register
// pending for a new ROB id; flush drops all pending state but keeps data.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  rf_scoreboard_if.slave bus
);

  reg_data_t [NUM_REGS-1:0] regs_r;
  logic      [NUM_REGS-1:0] pend_r;
  rob_id_t   [NUM_REGS-1:0] tag_r;
  pend_count_t              count_r;

  logic      [NUM_REGS-1:0] clr_s;
  logic      [NUM_REGS-1:0] set_s;
  logic      [NUM_REGS-1:0] pend_next_s;
  rob_id_t   [NUM_REGS-1:0] tag_next_s;

  // Per-register decode of commit-retire and allocate requests.
  always_comb begin
    clr_s = '0;
    set_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      clr_s[i] = bus.wb_writeEn && (bus.wb_dest == REG_AW'(i)) &&
                 pend_r[i] && (tag_r[i] == bus.wb_instr_id);
      set_s[i] = bus.alloc_valid && (bus.alloc_dest == REG_AW'(i)) && (i != 0);
    end
  end

  // Next pending/tag state: flush beats everything, allocate beats a retiring commit.
  always_comb begin
    pend_next_s = pend_r;
    tag_next_s  = tag_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.flush) begin
        pend_next_s[i] = 1'b0;
        tag_next_s[i]  = tag_r[i];
      end else if (set_s[i]) begin
        pend_next_s[i] = 1'b1;
        tag_next_s[i]  = bus.alloc_instr_id;
      end else if (clr_s[i]) begin
        pend_next_s[i] = 1'b0;
        tag_next_s[i]  = tag_r[i];
      end else begin
        pend_next_s[i] = pend_r[i];
        tag_next_s[i]  = tag_r[i];
      end
    end
  end

  // Register data: commits write even during a flush; r0 is never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_r <= '0;
    end else if (bus.wb_writeEn && (bus.wb_dest != '0)) begin
      regs_r[bus.wb_dest] <= bus.wb_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r  <= '0;
      tag_r   <= '0;
      count_r <= '0;
    end else begin
      pend_r  <= pend_next_s;
      tag_r   <= tag_next_s;
      count_r <= pend_popcount(pend_next_s);
    end
  end

  reg_data_t src1_data_s;
  reg_data_t src2_data_s;
  logic      src1_pending_s;
  logic      src2_pending_s;
  rob_id_t   src1_tag_s;
  rob_id_t   src2_tag_s;

  rf_read_port u_read_src1 (
    .addr        (bus.rd_src1_addr),
    .regs        (regs_r),
    .pend        (pend_r),
    .tags        (tag_r),
    .wb_write_en (bus.wb_writeEn),
    .wb_dest     (bus.wb_dest),
    .wb_data     (bus.wb_data),
    .wb_instr_id (bus.wb_instr_id),
    .data        (src1_data_s),
    .pending     (src1_pending_s),
    .tag         (src1_tag_s)
  );

  rf_read_port u_read_src2 (
    .addr        (bus.rd_src2_addr),
    .regs        (regs_r),
    .pend        (pend_r),
    .tags        (tag_r),
    .wb_write_en (bus.wb_writeEn),
    .wb_dest     (bus.wb_dest),
    .wb_data     (bus.wb_data),
    .wb_instr_id (bus.wb_instr_id),
    .data        (src2_data_s),
    .pending     (src2_pending_s),
    .tag         (src2_tag_s)
  );

  assign bus.rd_src1_data    = src1_data_s;
  assign bus.rd_src2_data    = src2_data_s;
  assign bus.rd_src1_pending = src1_pending_s;
  assign bus.rd_src2_pending = src2_pending_s;
  assign bus.rd_src1_tag     = src1_tag_s;
  assign bus.rd_src2_tag     = src2_tag_s;
  assign bus.pending_count   = count_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural register-file/scoreboard model.
module tb_rf_scoreboard;
  import rf_scoreboard_pkg::*;

  logic clock;
  logic reset;

  rf_scoreboard_if bus ();

  rf_scoreboard dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run;
  int tests_failed;

  // Behavioural model state.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int          m_tag  [32];

  // Last sampled read results (for directed constant checks).
  logic [31:0] s1_data, s2_data;
  logic        s1_pend, s2_pend;
  logic [2:0]  s1_tag,  s2_tag;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_pend[i] ? 1 : 0;
    return c;
  endfunction

  // Expected read for one address given the current commit inputs.
  task automatic model_read(input int a, output logic [31:0] d, output logic p, output logic [2:0] t);
    bit hit;
    hit = bus.wb_writeEn && (int'(bus.wb_dest) == a);
    if (a == 0) begin
      d = 32'h0; p = 1'b0; t = 3'd0;
    end else begin
      d = hit ? bus.wb_data : m_regs[a];
      p = m_pend[a] && !(hit && (m_tag[a] == int'(bus.wb_instr_id)));
      t = m_tag[a][2:0];
    end
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge();
    int d;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0; m_pend[i] = 1'b0; m_tag[i] = 0;
      end
    end else begin
      d = int'(bus.wb_dest);
      if (bus.wb_writeEn && d != 0) m_regs[d] = bus.wb_data;
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (bus.wb_writeEn && m_pend[d] && m_tag[d] == int'(bus.wb_instr_id)) m_pend[d] = 1'b0;
        if (bus.alloc_valid && bus.alloc_dest != 5'd0) begin
          m_pend[int'(bus.alloc_dest)] = 1'b1;
          m_tag[int'(bus.alloc_dest)]  = int'(bus.alloc_instr_id);
        end
      end
    end
  endtask

  // One cycle: drive inputs, check reads at negedge, advance model, check count.
  task automatic step(input logic av, input logic [4:0] ad, input logic [2:0] aid,
                      input logic we, input logic [31:0] wd, input logic [4:0] wdst,
                      input logic [2:0] wid, input logic fl, input logic rst,
                      input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] ed;
    logic        ep;
    logic [2:0]  et;
    bus.alloc_valid = av; bus.alloc_dest = ad; bus.alloc_instr_id = aid;
    bus.wb_writeEn = we; bus.wb_data = wd; bus.wb_dest = wdst; bus.wb_instr_id = wid;
    bus.flush = fl; reset = rst;
    bus.rd_src1_addr = a1; bus.rd_src2_addr = a2;
    @(negedge clock);
    s1_data = bus.rd_src1_data; s1_pend = bus.rd_src1_pending; s1_tag = bus.rd_src1_tag;
    s2_data = bus.rd_src2_data; s2_pend = bus.rd_src2_pending; s2_tag = bus.rd_src2_tag;
    model_read(int'(a1), ed, ep, et);
    check_eq("src1_data", s1_data, ed);
    check_eq("src1_pending", {31'd0, s1_pend}, {31'd0, ep});
    check_eq("src1_tag", {29'd0, s1_tag}, {29'd0, et});
    model_read(int'(a2), ed, ep, et);
    check_eq("src2_data", s2_data, ed);
    check_eq("src2_pending", {31'd0, s2_pend}, {31'd0, ep});
    check_eq("src2_tag", {29'd0, s2_tag}, {29'd0, et});
    @(posedge clock);
    model_edge();
    #1;
    check_eq("pending_count", {26'd0, bus.pending_count}, 32'(model_count()));
  endtask

  // Read-only cycle.
  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 5'd0, 3'd0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, a1, a2);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0; m_pend[i] = 1'b0; m_tag[i] = 0;
    end
    bus.alloc_valid = 1'b0; bus.alloc_dest = 5'd0; bus.alloc_instr_id = 3'd0;
    bus.wb_writeEn = 1'b0; bus.wb_data = 32'h0; bus.wb_dest = 5'd0; bus.wb_instr_id = 3'd0;
    bus.flush = 1'b0; bus.rd_src1_addr = 5'd0; bus.rd_src2_addr = 5'd0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // 1. reset state across all registers
    step(1'b0, 5'd0, 3'd0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b1, 5'd0, 5'd16);
    for (int i = 0; i < 16; i++) rd(5'(i), 5'(i + 16));
    check_eq("reset_count", {26'd0, bus.pending_count}, 32'd0);

    // 2. allocate r5 id 3, read, commit with same-cycle bypass
    step(1'b1, 5'd5, 3'd3, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd5, 5'd0);
    rd(5'd5, 5'd0);
    check_eq("t2_pend", {31'd0, s1_pend}, 32'd1);
    check_eq("t2_tag", {29'd0, s1_tag}, 32'd3);
    step(1'b0, 5'd0, 3'd0, 1'b1, 32'hDEADBEEF, 5'd5, 3'd3, 1'b0, 1'b0, 5'd5, 5'd5);
    check_eq("t2_bypass", s1_data, 32'hDEADBEEF);
    check_eq("t2_pend_clr", {31'd0, s1_pend}, 32'd0);
    check_eq("t2_count", {26'd0, bus.pending_count}, 32'd0);

    // 3. older writer commit leaves younger pending
    step(1'b1, 5'd7, 3'd1, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd7, 5'd0);
    step(1'b1, 5'd7, 3'd2, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 3'd0, 1'b1, 32'h11, 5'd7, 3'd1, 1'b0, 1'b0, 5'd7, 5'd0);
    rd(5'd7, 5'd0);
    check_eq("t3_data", s1_data, 32'h11);
    check_eq("t3_pend", {31'd0, s1_pend}, 32'd1);
    check_eq("t3_tag", {29'd0, s1_tag}, 32'd2);
    step(1'b0, 5'd0, 3'd0, 1'b1, 32'h22, 5'd7, 3'd2, 1'b0, 1'b0, 5'd0, 5'd7);
    rd(5'd7, 5'd0);
    check_eq("t3_data2", s1_data, 32'h22);
    check_eq("t3_pend2", {31'd0, s1_pend}, 32'd0);

    // 4. allocate and matching commit on the same register: allocate wins
    step(1'b1, 5'd9, 3'd0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd9, 5'd0);
    step(1'b1, 5'd9, 3'd4, 1'b1, 32'h99, 5'd9, 3'd0, 1'b0, 1'b0, 5'd9, 5'd0);
    rd(5'd9, 5'd0);
    check_eq("t4_pend", {31'd0, s1_pend}, 32'd1);
    check_eq("t4_tag", {29'd0, s1_tag}, 32'd4);
    check_eq("t4_data", s1_data, 32'h99);

    // 5. flush clears pending, ignores same-cycle allocate, keeps data
    step(1'b0, 5'd0, 3'd0, 1'b1, 32'h9A, 5'd9, 3'd4, 1'b0, 1'b0, 5'd9, 5'd0);
    step(1'b1, 5'd1, 3'd1, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd1, 5'd0);
    step(1'b1, 5'd2, 3'd2, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd2, 5'd0);
    step(1'b1, 5'd3, 3'd3, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd3, 5'd0);
    check_eq("t5_count3", {26'd0, bus.pending_count}, 32'd3);
    step(1'b1, 5'd4, 3'd5, 1'b0, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 5'd4, 5'd7);
    check_eq("t5_count0", {26'd0, bus.pending_count}, 32'd0);
    rd(5'd4, 5'd7);
    check_eq("t5_r4_pend", {31'd0, s1_pend}, 32'd0);
    check_eq("t5_r7_data", s2_data, 32'h22);

    // 6. r0 writes/allocates dropped; reset mid-stream clears pending
    step(1'b1, 5'd0, 3'd5, 1'b1, 32'hFFFFFFFF, 5'd0, 3'd5, 1'b0, 1'b0, 5'd0, 5'd0);
    check_eq("t6_r0_bypass", s1_data, 32'h0);
    rd(5'd0, 5'd0);
    check_eq("t6_r0_pend", {31'd0, s1_pend}, 32'd0);
    step(1'b1, 5'd10, 3'd6, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd11, 3'd7, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd10, 5'd11);
    step(1'b1, 5'd12, 3'd1, 1'b1, 32'h55, 5'd12, 3'd0, 1'b0, 1'b1, 5'd10, 5'd11);
    rd(5'd10, 5'd7);
    check_eq("t6_rst_pend", {31'd0, s1_pend}, 32'd0);
    check_eq("t6_rst_data", s2_data, 32'h0);
    check_eq("t6_rst_count", {26'd0, bus.pending_count}, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ad, wdst;
      logic [2:0] wid;
      wdst = 5'($urandom_range(0, 31));
      ad   = ($urandom_range(0, 3) == 0) ? wdst : 5'($urandom_range(0, 31));
      wid  = ($urandom_range(0, 1) == 0) ? m_tag[int'(wdst)][2:0] : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), ad, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom, wdst, wid,
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0),
           ($urandom_range(0, 1) == 0) ? wdst : 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
